// File: rtl/bombman_pkg.sv
// Shared bombman definitions: map item codes, the power-up lookup table
// and the item spawner FSM state encoding.
package bombman_pkg;

   localparam logic [3:0] ITEM_EMPTY   = 4'd0;
   localparam logic [3:0] ITEM_BOMB_UP = 4'd1;
   localparam logic [3:0] ITEM_FIRE_UP = 4'd2;
   localparam logic [3:0] ITEM_SPEED   = 4'd3;

   // Packed LUT indexed by rnd[1:0]: [0]=BOMB_UP [1]=FIRE_UP [2]=SPEED [3]=BOMB_UP
   localparam logic [3:0][3:0] ITEM_LUT = {ITEM_BOMB_UP, ITEM_SPEED, ITEM_FIRE_UP, ITEM_BOMB_UP};

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_SAMP_X = 3'd1,
      S_SAMP_Y = 3'd2,
      S_READ   = 3'd3,
      S_WAIT   = 3'd4,
      S_CHECK  = 3'd5,
      S_WRITE  = 3'd6
   } spawn_state_e;

endpackage

// File: rtl/rnd_item_spawner.sv
// Random power-up spawner: rejection-samples grid coordinates from the rnd
// stream, reads the map cell and writes an item code when the cell is empty.
module rnd_item_spawner
   import bombman_pkg::*;
#(
   parameter int unsigned GRID_W    = 8,
   parameter int unsigned GRID_H    = 8,
   parameter int unsigned MAX_TRIES = 15,
   parameter int unsigned ADDR_W    = 6
) (
   input  logic              clock_i,
   input  logic              reset_i,
   input  logic [3:0]        rnd_i,
   input  logic              spawn_req_i,
   output logic              rd_en_o,
   output logic [ADDR_W-1:0] rd_addr_o,
   input  logic [3:0]        rd_data_i,
   output logic              wr_en_o,
   output logic [ADDR_W-1:0] wr_addr_o,
   output logic [3:0]        wr_data_o,
   output logic [3:0]        spawn_x_o,
   output logic [3:0]        spawn_y_o,
   output logic              busy_o,
   output logic              done_o,
   output logic              fail_o
);

   localparam int unsigned TRY_W = $clog2(MAX_TRIES + 1);

   spawn_state_e      state_q, state_d;
   logic [TRY_W-1:0]  tries_q, tries_d, tries_inc;
   logic [3:0]        x_q, x_d, y_q, y_d;
   logic [3:0]        cell_q, cell_d;
   logic [ADDR_W-1:0] rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d;
   logic [3:0]        wr_data_q, wr_data_d;
   logic [3:0]        spawn_x_q, spawn_x_d, spawn_y_q, spawn_y_d;
   logic              rd_en_q, rd_en_d, wr_en_q, wr_en_d;
   logic              busy_q, busy_d, done_q, done_d, fail_q, fail_d;
   logic              reject;

   // State, datapath and registered outputs
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         state_q   <= S_IDLE;
         tries_q   <= '0;
         x_q       <= '0;
         y_q       <= '0;
         cell_q    <= '0;
         rd_addr_q <= '0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         spawn_x_q <= '0;
         spawn_y_q <= '0;
         rd_en_q   <= 1'b0;
         wr_en_q   <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         fail_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         tries_q   <= tries_d;
         x_q       <= x_d;
         y_q       <= y_d;
         cell_q    <= cell_d;
         rd_addr_q <= rd_addr_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         spawn_x_q <= spawn_x_d;
         spawn_y_q <= spawn_y_d;
         rd_en_q   <= rd_en_d;
         wr_en_q   <= wr_en_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         fail_q    <= fail_d;
      end
   end

   // Next-state and output decode
   always_comb begin
      state_d   = state_q;
      tries_d   = tries_q;
      x_d       = x_q;
      y_d       = y_q;
      cell_d    = cell_q;
      rd_addr_d = rd_addr_q;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      spawn_x_d = spawn_x_q;
      spawn_y_d = spawn_y_q;
      wr_en_d   = 1'b0;
      done_d    = 1'b0;
      fail_d    = 1'b0;
      reject    = 1'b0;
      tries_inc = tries_q + TRY_W'(1);

      unique case (state_q)
         S_IDLE: begin
            if (spawn_req_i) begin
               state_d = S_SAMP_X;
               tries_d = '0;
            end
         end
         S_SAMP_X: begin
            if ({1'b0, rnd_i} < 5'(GRID_W)) begin
               x_d     = rnd_i;
               state_d = S_SAMP_Y;
            end else begin
               reject = 1'b1;
            end
         end
         S_SAMP_Y: begin
            if ({1'b0, rnd_i} < 5'(GRID_H)) begin
               y_d       = rnd_i;
               rd_addr_d = ADDR_W'(ADDR_W'(rnd_i) * ADDR_W'(GRID_W)) + ADDR_W'(x_q);
               state_d   = S_READ;
            end else begin
               reject = 1'b1;
            end
         end
         S_READ:  state_d = S_WAIT;
         S_WAIT: begin
            cell_d  = rd_data_i;
            state_d = S_CHECK;
         end
         S_CHECK: begin
            if (cell_q == ITEM_EMPTY) begin
               state_d = S_WRITE;
            end else begin
               reject  = 1'b1;
               state_d = S_SAMP_X;
            end
         end
         S_WRITE: begin
            wr_en_d   = 1'b1;
            wr_addr_d = rd_addr_q;
            wr_data_d = ITEM_LUT[rnd_i[1:0]];
            spawn_x_d = x_q;
            spawn_y_d = y_q;
            done_d    = 1'b1;
            state_d   = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      // Every rejection consumes budget; the increment reaching the limit aborts
      if (reject) begin
         tries_d = tries_inc;
         if (tries_inc == TRY_W'(MAX_TRIES)) begin
            state_d = S_IDLE;
            fail_d  = 1'b1;
         end
      end

      rd_en_d = (state_d == S_READ);
      busy_d  = (state_d != S_IDLE);
   end

   assign rd_en_o   = rd_en_q;
   assign rd_addr_o = rd_addr_q;
   assign wr_en_o   = wr_en_q;
   assign wr_addr_o = wr_addr_q;
   assign wr_data_o = wr_data_q;
   assign spawn_x_o = spawn_x_q;
   assign spawn_y_o = spawn_y_q;
   assign busy_o    = busy_q;
   assign done_o    = done_q;
   assign fail_o    = fail_q;

endmodule

// File: tb/tb_rnd_item_spawner.sv
// Self-checking bench for rnd_item_spawner: directed vector table, multi-cycle
// corner sequences and a randomized scoreboard run against a bench-side map RAM.
module tb_rnd_item_spawner;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] rnd = '0;
   logic       spawn_req = 1'b0;
   logic       rd_en, wr_en, busy, done, fail;
   logic [5:0] rd_addr, wr_addr;
   logic [3:0] rd_data = '0;
   logic [3:0] wr_data, spawn_x, spawn_y;

   int n_chk = 0;
   int n_fail = 0;
   int wr_seen = 0;
   int ecnt = 0;
   int busy_err = 0;
   int done_q[$];
   int fail_q[$];
   bit sb_on = 1'b0;

   typedef struct packed {
      logic [5:0] addr;
      logic [3:0] data;
   } exp_t;
   exp_t exp_q[$];

   typedef struct {
      logic [3:0] rnd;
      logic       req;
      logic       rd_en;
      logic [5:0] rd_addr;
      logic       wr_en;
      logic [5:0] wr_addr;
      logic [3:0] wr_data;
      logic       busy;
      logic       done;
   } vec_t;
   vec_t tv[8];

   logic [3:0] mem [64];
   logic       clr_en = 1'b0;
   logic       ld_en = 1'b0;
   logic [5:0] ld_addr = '0;
   logic [3:0] ld_data = '0;

   rnd_item_spawner #(
      .GRID_W(8), .GRID_H(8), .MAX_TRIES(15), .ADDR_W(6)
   ) dut (
      .clock_i    (clk),
      .reset_i    (rst),
      .rnd_i      (rnd),
      .spawn_req_i(spawn_req),
      .rd_en_o    (rd_en),
      .rd_addr_o  (rd_addr),
      .rd_data_i  (rd_data),
      .wr_en_o    (wr_en),
      .wr_addr_o  (wr_addr),
      .wr_data_o  (wr_data),
      .spawn_x_o  (spawn_x),
      .spawn_y_o  (spawn_y),
      .busy_o     (busy),
      .done_o     (done),
      .fail_o     (fail)
   );

   always #5 clk = ~clk;

   // Map RAM: registered read, write port, plus bench-side clear and load
   always @(posedge clk) begin
      if (rd_en) rd_data <= mem[rd_addr];
      if (clr_en) for (int i = 0; i < 64; i++) mem[i] <= 4'd0;
      if (ld_en) mem[ld_addr] <= ld_data;
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic logic [3:0] item_exp(input logic [1:0] sel);
      case (sel)
         2'd0:    return 4'd1;
         2'd1:    return 4'd2;
         2'd2:    return 4'd3;
         default: return 4'd1;
      endcase
   endfunction

   // Scoreboard monitor on the write port
   always @(negedge clk) begin
      if (wr_en) begin
         wr_seen++;
         if (sb_on) begin
            chk("sb pending", 32'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
               exp_t e;
               e = exp_q.pop_front();
               chk("sb wr_addr", 32'(wr_addr), 32'(e.addr));
               chk("sb wr_data", 32'(wr_data), 32'(e.data));
            end
            chk("sb target empty", 32'(mem[wr_addr]), 0);
         end
      end
   end

   task automatic cyc(input logic [3:0] r, input logic q);
      rnd = r;
      spawn_req = q;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic rc(input logic [3:0] r, input logic q);
      cyc(r, q);
      ecnt++;
      if (done) done_q.push_back(ecnt);
      if (fail) fail_q.push_back(ecnt);
      if ((done || fail) && busy) busy_err++;
      if (done && fail) busy_err++;
   endtask

   task automatic rc_reset();
      ecnt = 0;
      busy_err = 0;
      done_q.delete();
      fail_q.delete();
   endtask

   task automatic clear_map();
      clr_en = 1'b1;
      cyc(4'd0, 1'b0);
      clr_en = 1'b0;
   endtask

   task automatic load(input int a, input logic [3:0] d);
      ld_en = 1'b1;
      ld_addr = 6'(a);
      ld_data = d;
      cyc(4'd0, 1'b0);
      ld_en = 1'b0;
   endtask

   int occ_x[6];
   int occ_y[6];
   int filled = 0;

   task automatic clear_and_seed();
      clear_map();
      for (int i = 0; i < 6; i++) begin
         occ_x[i] = int'($urandom_range(0, 7));
         occ_y[i] = int'($urandom_range(0, 7));
         load(occ_y[i] * 8 + occ_x[i], 4'($urandom_range(1, 15)));
      end
      filled = 0;
   endtask

   // One coordinate draw: random rejections, accepted x/y, then READ/WAIT/CHECK
   task automatic attempt(input int x, input int y);
      int rx;
      int ry;
      rx = int'($urandom_range(0, 2));
      ry = int'($urandom_range(0, 2));
      repeat (rx) cyc(4'($urandom_range(8, 15)), 1'b0);
      cyc(4'(x), 1'b0);
      repeat (ry) cyc(4'($urandom_range(8, 15)), 1'b0);
      cyc(4'(y), 1'b0);
      repeat (3) cyc(4'($urandom_range(0, 15)), 1'b0);
   endtask

   function automatic vec_t mk(input logic [3:0] r, input logic q, input logic re,
                               input logic [5:0] ra, input logic we, input logic [5:0] wa,
                               input logic [3:0] wd, input logic b, input logic d);
      vec_t v;
      v.rnd = r; v.req = q; v.rd_en = re; v.rd_addr = ra; v.wr_en = we;
      v.wr_addr = wa; v.wr_data = wd; v.busy = b; v.done = d;
      return v;
   endfunction

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int wr0;
      logic [3:0] w;
      int tx;
      int ty;
      logic [3:0] rs [14];
      logic       qs [14];

      // Best-case spawn: x=3, y=5 -> addr 43, WRITE rnd=2 -> SPEED
      tv[0] = mk(4'd0, 1'b1, 1'b0, 6'd0,  1'b0, 6'd0,  4'd0, 1'b1, 1'b0);
      tv[1] = mk(4'd3, 1'b0, 1'b0, 6'd0,  1'b0, 6'd0,  4'd0, 1'b1, 1'b0);
      tv[2] = mk(4'd5, 1'b0, 1'b1, 6'd43, 1'b0, 6'd0,  4'd0, 1'b1, 1'b0);
      tv[3] = mk(4'd0, 1'b0, 1'b0, 6'd43, 1'b0, 6'd0,  4'd0, 1'b1, 1'b0);
      tv[4] = mk(4'd0, 1'b0, 1'b0, 6'd43, 1'b0, 6'd0,  4'd0, 1'b1, 1'b0);
      tv[5] = mk(4'd0, 1'b0, 1'b0, 6'd43, 1'b0, 6'd0,  4'd0, 1'b1, 1'b0);
      tv[6] = mk(4'd2, 1'b0, 1'b0, 6'd43, 1'b1, 6'd43, 4'd3, 1'b0, 1'b1);
      tv[7] = mk(4'd0, 1'b0, 1'b0, 6'd43, 1'b0, 6'd43, 4'd3, 1'b0, 1'b0);

      // Reset with map clear
      rst = 1'b1;
      clear_map();
      cyc(4'd0, 1'b1);
      chk("reset busy", 32'(busy), 0);
      chk("reset rd_en", 32'(rd_en), 0);
      chk("reset wr_en", 32'(wr_en), 0);
      chk("reset done", 32'(done), 0);
      chk("reset fail", 32'(fail), 0);
      chk("reset rd_addr", 32'(rd_addr), 0);
      chk("reset wr_addr", 32'(wr_addr), 0);
      chk("reset wr_data", 32'(wr_data), 0);
      chk("reset spawn_xy", 32'({spawn_x, spawn_y}), 0);
      rst = 1'b0;
      cyc(4'd0, 1'b0);
      chk("idle busy", 32'(busy), 0);

      // Test 1: table-driven best case
      for (int i = 0; i < 8; i++) begin
         cyc(tv[i].rnd, tv[i].req);
         chk($sformatf("t1[%0d] rd_en", i),   32'(rd_en),   32'(tv[i].rd_en));
         chk($sformatf("t1[%0d] rd_addr", i), 32'(rd_addr), 32'(tv[i].rd_addr));
         chk($sformatf("t1[%0d] wr_en", i),   32'(wr_en),   32'(tv[i].wr_en));
         chk($sformatf("t1[%0d] wr_addr", i), 32'(wr_addr), 32'(tv[i].wr_addr));
         chk($sformatf("t1[%0d] wr_data", i), 32'(wr_data), 32'(tv[i].wr_data));
         chk($sformatf("t1[%0d] busy", i),    32'(busy),    32'(tv[i].busy));
         chk($sformatf("t1[%0d] done", i),    32'(done),    32'(tv[i].done));
         chk($sformatf("t1[%0d] fail", i),    32'(fail),    0);
      end
      chk("t1 spawn_x", 32'(spawn_x), 3);
      chk("t1 spawn_y", 32'(spawn_y), 5);
      chk("t1 map[43]", 32'(mem[43]), 3);

      // Test 2: X rejections 9,12 then x=2; one Y rejection 15 then y=1
      clear_map();
      rc_reset();
      rc(4'd0, 1'b1);
      rc(4'd9, 1'b0);
      rc(4'd12, 1'b0);
      rc(4'd2, 1'b0);
      rc(4'd15, 1'b0);
      rc(4'd1, 1'b0);
      for (int k = 0; k < 12 && done_q.size() == 0; k++) rc(4'd0, 1'b0);
      chk("t2 done seen", 32'(done_q.size()), 1);
      if (done_q.size() > 0) chk("t2 done edge", 32'(done_q[0]), 10);
      chk("t2 wr_addr", 32'(wr_addr), 10);
      chk("t2 wr_data", 32'(wr_data), 1);
      chk("t2 spawn_xy", 32'({spawn_x, spawn_y}), 32'({4'd2, 4'd1}));
      chk("t2 busy/done/fail overlap", 32'(busy_err), 0);

      // Test 3: cell (1,1) occupied every draw -> budget of 15 exhausted
      clear_map();
      load(9, 4'd2);
      wr0 = wr_seen;
      rc_reset();
      rc(4'd0, 1'b1);
      for (int a = 0; a < 15; a++) begin
         rc(4'd1, 1'b0);
         rc(4'd1, 1'b0);
         rc(4'd0, 1'b0);
         rc(4'd0, 1'b0);
         rc(4'd0, 1'b0);
      end
      rc(4'd0, 1'b0);
      rc(4'd0, 1'b0);
      chk("t3 fail count", 32'(fail_q.size()), 1);
      if (fail_q.size() > 0) chk("t3 fail edge", 32'(fail_q[0]), 76);
      chk("t3 done count", 32'(done_q.size()), 0);
      chk("t3 no write", 32'(wr_seen - wr0), 0);
      chk("t3 map[9]", 32'(mem[9]), 2);
      chk("t3 busy overlap", 32'(busy_err), 0);

      // Test 4: requests while busy ignored; request during done accepted
      clear_map();
      rs = '{4'd0, 4'd1, 4'd2, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd4, 4'd4, 4'd0, 4'd0, 4'd0, 4'd1};
      qs = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      rc_reset();
      for (int i = 0; i < 14; i++) rc(rs[i], qs[i]);
      for (int i = 0; i < 4; i++) rc(4'd0, 1'b0);
      chk("t4 done count", 32'(done_q.size()), 2);
      if (done_q.size() > 1) begin
         chk("t4 done edge A", 32'(done_q[0]), 7);
         chk("t4 done edge B", 32'(done_q[1]), 14);
      end
      chk("t4 map[17]", 32'(mem[17]), 1);
      chk("t4 map[36]", 32'(mem[36]), 2);
      chk("t4 fail count", 32'(fail_q.size()), 0);
      chk("t4 busy overlap", 32'(busy_err), 0);

      // Test 5: reset while in WRITE drops the pending write
      clear_map();
      wr0 = wr_seen;
      cyc(4'd0, 1'b1);
      cyc(4'd6, 1'b0);
      cyc(4'd6, 1'b0);
      cyc(4'd0, 1'b0);
      cyc(4'd0, 1'b0);
      cyc(4'd0, 1'b0);
      rst = 1'b1;
      cyc(4'd2, 1'b0);
      chk("t5 wr_en", 32'(wr_en), 0);
      chk("t5 busy", 32'(busy), 0);
      chk("t5 done", 32'(done), 0);
      rst = 1'b0;
      cyc(4'd0, 1'b0);
      cyc(4'd0, 1'b0);
      chk("t5 no write", 32'(wr_seen - wr0), 0);
      chk("t5 map[54]", 32'(mem[54]), 0);

      // Test 6: randomized spawns with scoreboard
      exp_q.delete();
      sb_on = 1'b1;
      clear_and_seed();
      for (int s = 0; s < 1000; s++) begin
         if (filled >= 24) clear_and_seed();
         cyc(4'($urandom_range(0, 15)), 1'b1);
         if ($urandom_range(0, 1) == 1) begin
            int idx;
            idx = int'($urandom_range(0, 5));
            attempt(occ_x[idx], occ_y[idx]);
         end
         do begin
            tx = int'($urandom_range(0, 7));
            ty = int'($urandom_range(0, 7));
         end while (mem[ty * 8 + tx] != 4'd0);
         attempt(tx, ty);
         w = 4'($urandom_range(0, 15));
         begin
            exp_t e;
            e.addr = 6'(ty * 8 + tx);
            e.data = item_exp(w[1:0]);
            exp_q.push_back(e);
         end
         cyc(w, 1'b0);
         chk($sformatf("t6[%0d] done", s), 32'(done), 1);
         chk($sformatf("t6[%0d] fail", s), 32'(fail), 0);
         chk($sformatf("t6[%0d] spawn_xy", s), 32'({spawn_x, spawn_y}), 32'({4'(tx), 4'(ty)}));
         filled++;
      end
      cyc(4'd0, 1'b0);
      cyc(4'd0, 1'b0);
      chk("t6 queue drained", 32'(exp_q.size()), 0);
      sb_on = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
